// File: rtl/rle_row_decompressor.sv
// Run-length decoder: expands {value, length} run words into packed pixel rows
// and hands each finished row downstream over a valid/ready handshake.
module rle_row_decompressor #(
    parameter int ROW_W = 28,
    parameter int ROWS  = 28,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_decompression,
    input  logic [15:0]      data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic [ROW_W-1:0] row_out,
    output logic [IDX_W-1:0] row_idx,
    output logic             row_valid,
    input  logic             row_ready,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam int COL_W = $clog2(ROW_W + 1);
    localparam int RUN_W = 15;
    localparam logic [COL_W-1:0] ROW_W_C  = COL_W'(ROW_W);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXPAND,
        S_EMIT,
        S_DONE
    } state_t;

    state_t           state,   state_nx;
    logic [ROW_W-1:0] row_buf, row_buf_nx;
    logic [COL_W-1:0] col,     col_nx;
    logic [RUN_W-1:0] run_rem, run_rem_nx;
    logic             run_val, run_val_nx;
    logic [IDX_W-1:0] idx,     idx_nx;
    logic             done_q,  done_nx;
    logic             ovf_q,   ovf_nx;

    logic [COL_W-1:0] space;
    logic [COL_W-1:0] seg_n;
    logic [COL_W-1:0] seg_end;
    logic [ROW_W-1:0] seg_mask;

    // One segment per cycle: the part of the current run that fits in this row.
    // Column 0 is the MSB, so the segment covers bits [ROW_W-1-col : ROW_W-seg_end].
    always_comb begin
        space    = ROW_W_C - col;
        seg_n    = (run_rem < RUN_W'(space)) ? COL_W'(run_rem) : space;
        seg_end  = col + seg_n;
        seg_mask = ({ROW_W{1'b1}} >> col) & ~({ROW_W{1'b1}} >> seg_end);
    end

    // NOTE: every signal written here gets a default first, so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        state_nx   = state;
        row_buf_nx = row_buf;
        col_nx     = col;
        run_rem_nx = run_rem;
        run_val_nx = run_val;
        idx_nx     = idx;
        done_nx    = done_q;
        ovf_nx     = ovf_q;
        data_ready = 1'b0;
        row_valid  = 1'b0;
        busy       = 1'b0;

        unique case (state)
            S_IDLE, S_DONE: begin
                if (start_decompression) begin
                    state_nx   = S_FETCH;
                    col_nx     = '0;
                    idx_nx     = '0;
                    row_buf_nx = '0;
                    run_rem_nx = '0;
                    done_nx    = 1'b0;
                    ovf_nx     = 1'b0;
                end
            end

            S_FETCH: begin
                data_ready = 1'b1;
                busy       = 1'b1;
                if (data_valid) begin
                    run_val_nx = data_in[15];
                    run_rem_nx = data_in[14:0];
                    // A zero-length word is swallowed without touching the row.
                    if (data_in[14:0] != '0) begin
                        state_nx = S_EXPAND;
                    end
                end
            end

            S_EXPAND: begin
                busy       = 1'b1;
                row_buf_nx = run_val ? (row_buf | seg_mask) : (row_buf & ~seg_mask);
                col_nx     = seg_end;
                run_rem_nx = run_rem - RUN_W'(seg_n);
                state_nx   = (seg_end == ROW_W_C) ? S_EMIT : S_FETCH;
            end

            S_EMIT: begin
                busy      = 1'b1;
                row_valid = 1'b1;
                if (row_ready) begin
                    row_buf_nx = '0;
                    col_nx     = '0;
                    if (idx == LAST_ROW) begin
                        state_nx = S_DONE;
                        done_nx  = 1'b1;
                        ovf_nx   = (run_rem != '0);
                    end else begin
                        idx_nx   = idx + IDX_W'(1);
                        state_nx = (run_rem != '0) ? S_EXPAND : S_FETCH;
                    end
                end
            end

            default: state_nx = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            row_buf <= '0;
            col     <= '0;
            run_rem <= '0;
            run_val <= 1'b0;
            idx     <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            row_buf <= row_buf_nx;
            col     <= col_nx;
            run_rem <= run_rem_nx;
            run_val <= run_val_nx;
            idx     <= idx_nx;
            done_q  <= done_nx;
            ovf_q   <= ovf_nx;
        end
    end

    assign row_out  = row_buf;
    assign row_idx  = idx;
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule

// File: doc/rle_row_decompressor.md
Name: rle_row_decompressor

Overview:
- Sits directly downstream of the cpu stage. Consumes its 16-bit compressed word stream and rebuilds the image one packed pixel row at a time.
- Each input word is a run: bit 15 = pixel value, bits 14:0 = run length. The block expands runs into a ROW_W-bit row buffer and hands each completed row to the DCNN core with a valid/ready handshake.
- Runs may span row boundaries. Decompression stops after ROWS rows.

Parameters:
- ROW_W, 28: pixels per row; width of row_out.
- ROWS, 28: rows per image.
- IDX_W, 8: width of row_idx; must satisfy 2^IDX_W >= ROWS.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_decompression  in  1  one-cycle start pulse; sampled only in IDLE or DONE.
- data_in  in  16  run word: [15] pixel value, [14:0] run length.
- data_valid  in  1  data_in holds a valid word.
- data_ready  out  1  block accepts data_in this cycle.
- row_out  out  ROW_W  completed row; column 0 at bit ROW_W-1 (MSB first).
- row_idx  out  IDX_W  index of the row currently on row_out, 0..ROWS-1.
- row_valid  out  1  row_out/row_idx valid.
- row_ready  in  1  consumer accepts the row.
- busy  out  1  high in FETCH, EXPAND and EMIT.
- done  out  1  sticky; high once ROWS rows have been handed off.
- overflow  out  1  sticky; run data remained after the last row.

Behaviour:
- Reset (rst=0, async):
  - State IDLE.
  - row_buf=0, col=0, run_rem=0, run_val=0, row_idx=0.
  - data_ready=0, row_valid=0, busy=0, done=0, overflow=0.
- Internal widths: col is clog2(ROW_W+1) bits; run_rem is 15 bits.
- IDLE:
  - data_ready=0.
  - start_decompression=1 -> FETCH; clear col, row_idx, row_buf, done, overflow.
- FETCH:
  - data_ready=1.
  - On data_valid&data_ready: run_val<=data_in[15], run_rem<=data_in[14:0].
  - If length=0, the word is consumed as a no-op and the state stays FETCH. Otherwise -> EXPAND.
- EXPAND (data_ready=0), one segment per cycle:
  - n = min(run_rem, ROW_W-col).
  - Bits for columns col..col+n-1 <= run_val (bits [ROW_W-1-col] down to [ROW_W-col-n]).
  - col<=col+n; run_rem<=run_rem-n.
  - Next state: if col+n==ROW_W -> EMIT; else (run exhausted) -> FETCH.
- EMIT:
  - row_valid=1; row_out and row_idx held stable until row_ready=1.
  - On handshake: clear row_buf, col<=0.
  - If row_idx==ROWS-1 -> DONE, and overflow<=1 if run_rem!=0.
  - Otherwise row_idx<=row_idx+1; then -> EXPAND if run_rem!=0, else -> FETCH.
  - row_valid deasserts the cycle after the handshake.
- DONE:
  - done=1, busy=0, data_ready=0; all further input words are ignored.
  - start_decompression=1 restarts exactly as from IDLE (done and overflow clear on the next edge).
- Latency:
  - One cycle from word acceptance to first EXPAND.
  - A row whose final run arrives in word k has row_valid high 2 cycles after word k is accepted, provided that run fits in the row.
  - Back-to-back throughput: at most one word per 2 cycles.
- Simultaneous events:
  - start_decompression outside IDLE/DONE is ignored.
  - row_ready outside EMIT is ignored.
  - data_valid outside FETCH is not consumed.
- Reset mid-operation: an in-flight row is discarded, no row_valid is produced, and all outputs return to reset values asynchronously.

Test Plan:
- Reset, then start. Feed 28 words of 0x801C (value 1, length 28) with row_ready=1 -> 28 row_valid pulses, row_out=0xFFFFFFF, row_idx 0..27, done=1, overflow=0.
- Start, then feed 0x000A and 0x8020 (10 zeros, then 32 ones) -> row 0 = 0x003FFFF. The run carries over 14 ones: row 1 starts 0xFFFC000 pending; with next word 0x000E, row 1 = 0xFFFC000.
- Backpressure: hold row_ready=0 for 5 cycles during EMIT -> row_valid, row_out and row_idx stable, data_ready=0; both words stay pending with data_valid=1 and none is consumed.
- Zero-length word 0x8000 in FETCH -> consumed, no pixel change, col unchanged, state stays FETCH.
- Overflow: full image followed by a final run of length 40 spanning the last row -> done=1, overflow=1; subsequent words are not accepted (data_ready=0).
- Drive rst=0 mid-EXPAND on row 3, then release and start -> row_idx restarts at 0, row_valid never asserts for the partial row, done=0.
